// File: rtl/ram_stream_reader_pkg.sv
// Shared types and default sizing for the RAM burst-to-stream reader.
package ram_stream_reader_pkg;

    localparam int DEFAULT_DEPTH = 4096;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ram_as_DxWb_rrw_p1p1.sv
// Simple dual-port RAM: port A write/read, port B read, one-cycle registered reads.
module ram_as_DxWb_rrw_p1p1 #(
    parameter int  DEPTH     = 4096,
    parameter int  WIDTH     = 16,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] address_a,
    input  logic                 wren_a,
    input  logic [WIDTH-1:0]     data_a,
    output logic [WIDTH-1:0]     q_a,
    input  logic [ADDR_BITS-1:0] address_b,
    input  logic                 rden_b,
    output logic [WIDTH-1:0]     q_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wren_a) begin
            mem[address_a] <= data_a;
        end
        q_a <= mem[address_a];
        if (rden_b) begin
            q_b <= mem[address_b];
        end
    end

endmodule

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry FIFO holding captured read data plus its end-of-burst flag.
module ram_stream_reader_fifo #(
    parameter int W = 17
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_reg;
    assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from RAM port B and presents them as a ready/valid stream.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int  DEPTH     = DEFAULT_DEPTH,
    parameter int  WIDTH     = DEFAULT_WIDTH,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] address_b,
    output logic                 rd_b,
    input  logic [WIDTH-1:0]     q_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last
);

    state_t               state_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [ADDR_BITS:0]   remaining_reg;
    logic                 inflight_reg;
    logic                 last_inflight_reg;
    logic                 done_reg;

    logic [1:0]           fifo_count;
    logic [WIDTH:0]       fifo_head;
    logic [2:0]           occupancy;
    logic                 pop;
    logic                 issue;
    logic                 issue_last;

    assign pop       = out_valid & out_ready;
    // Entries that will sit in the FIFO next cycle if nothing new issues.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};

    assign issue      = (state_reg == RUN) && (remaining_reg != '0) && (occupancy < 3'd2);
    assign issue_last = issue && (remaining_reg == (ADDR_BITS+1)'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            remaining_reg     <= '0;
            inflight_reg      <= 1'b0;
            last_inflight_reg <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            done_reg          <= 1'b0;
            inflight_reg      <= issue;
            last_inflight_reg <= issue_last;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_reg      <= start_addr;
                            remaining_reg <= length;
                            state_reg     <= RUN;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_reg      <= addr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (issue_last) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_head[WIDTH]) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read data lands on q_b the cycle after rd_b; capture it then.
    ram_stream_reader_fifo #(
        .W(WIDTH + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data ({last_inflight_reg, q_b}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign rd_b      = issue;
    assign address_b = addr_reg;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = out_valid ? fifo_head[WIDTH-1:0] : '0;
    assign out_last  = out_valid & fifo_head[WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench: RAM preloaded with mem[i]=i, bursts read back and checked beat by beat.
module tb_ram_stream_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] start_addr = '0;
    logic [12:0] length = '0;
    logic        busy, done, rd_b, out_valid, out_last;
    logic        out_ready = 1'b0;
    logic [11:0] address_b;
    logic [15:0] q_b, out_data, q_a;
    logic [11:0] address_a = '0;
    logic        wren_a = 1'b0;
    logic [15:0] data_a = '0;

    int n_assert = 0;
    int n_fail   = 0;

    int cyc = 0;
    int start_cyc, first_valid_cyc, done_cyc;
    int rd_cnt, done_cnt, valid_cnt;
    logic [16:0] beats[$];
    logic        stall_prev = 1'b0;
    logic [16:0] stall_val;

    always #5 clock = ~clock;

    ram_stream_reader u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .address_b  (address_b),
        .rd_b       (rd_b),
        .q_b        (q_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    ram_as_DxWb_rrw_p1p1 #(.DEPTH(4096), .WIDTH(16)) u_ram (
        .clock     (clock),
        .address_a (address_a),
        .wren_a    (wren_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .address_b (address_b),
        .rden_b    (rd_b),
        .q_b       (q_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_counters();
        start_cyc       = -1;
        first_valid_cyc = -1;
        done_cyc        = -1;
        rd_cnt          = 0;
        done_cnt        = 0;
        valid_cnt       = 0;
        beats.delete();
    endtask

    // Cycle monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (start && !busy) start_cyc = cyc;
            if (rd_b) rd_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_valid && out_ready) beats.push_back({out_last, out_data});
            if (stall_prev) chk("stall_hold", {15'd0, out_valid, out_last, out_data}, {15'd0, 1'b1, stall_val});
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_last, out_data};
            if (u_dut.inflight_reg) chk("fifo_no_overflow", {30'd0, u_dut.fifo_count == 2'd2}, 32'd0);
        end
    end

    task automatic do_burst(input logic [11:0] a, input logic [12:0] n,
                            input bit toggle, input bit restart);
        logic [3:0]  pat;
        logic [11:0] exp_a;
        int          sc;
        pat = toggle ? 4'b1001 : 4'b1111;
        clear_counters();
        start      = 1'b1;
        start_addr = a;
        length     = n;
        out_ready  = pat[0];
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, {31'd0, n != 13'd0});
        for (int k = 1; k < 400; k++) begin
            if (done_cnt != 0) break;
            if (restart && k == 2) begin
                start      = 1'b1;
                start_addr = 12'h300;
                length     = 13'd7;
            end
            if (k == 3) start = 1'b0;
            out_ready = pat[k % 4];
            tick();
        end
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        sc = beats.size();
        chk("done_pulses", done_cnt, 32'd1);
        chk("beat_count", sc, {19'd0, n});
        chk("read_count", rd_cnt, {19'd0, n});
        for (int i = 0; i < int'(n) && i < sc; i++) begin
            exp_a = a + 12'(i);
            chk("beat_data", {16'd0, beats[i][15:0]}, {20'd0, exp_a});
            chk("beat_last", {31'd0, beats[i][16]}, {31'd0, i == int'(n) - 1});
        end
        $display("burst addr=%03h len=%0d beats=%0d dones=%0d", a, n, sc, done_cnt);
    endtask

    initial begin
        clear_counters();
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_b", {31'd0, rd_b}, 32'd0);
        chk("rst_address_b", {20'd0, address_b}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);

        for (int i = 0; i < 4096; i++) begin
            wren_a    = 1'b1;
            address_a = 12'(i);
            data_a    = 16'(i);
            tick();
        end
        wren_a = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Basic burst with first-beat latency.
        do_burst(12'h010, 13'd4, 1'b0, 1'b0);
        chk("first_valid_latency", first_valid_cyc - start_cyc, 32'd3);

        // Address wrap at the top of the RAM.
        do_burst(12'hFFE, 13'd4, 1'b0, 1'b0);

        // Backpressure with ready pattern 1,0,0,1.
        do_burst(12'h080, 13'd8, 1'b1, 1'b0);

        // Zero-length request.
        do_burst(12'h020, 13'd0, 1'b0, 1'b0);
        chk("len0_done_latency", done_cyc - start_cyc, 32'd1);
        chk("len0_valid_cycles", valid_cnt, 32'd0);

        // Second start while busy must be ignored.
        do_burst(12'h040, 13'd5, 1'b0, 1'b1);

        // Reset mid-burst.
        clear_counters();
        start      = 1'b1;
        start_addr = 12'h200;
        length     = 13'd10;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (beats.size() >= 3) break;
            tick();
        end
        chk("abort_reached_3_beats", {31'd0, beats.size() >= 3}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rd_b", {31'd0, rd_b}, 32'd0);
        chk("abort_address_b", {20'd0, address_b}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_last", {31'd0, out_last}, 32'd0);
        chk("abort_out_data", {16'd0, out_data}, 32'd0);
        $display("reset mid-burst after %0d beats", beats.size());
        tick();
        tick();
        reset = 1'b0;
        clear_counters();
        for (int k = 0; k < 8; k++) tick();
        chk("post_abort_beats", beats.size(), 32'd0);
        chk("post_abort_done", done_cnt, 32'd0);
        chk("post_abort_reads", rd_cnt, 32'd0);

        // Start presented in the very first cycle after reset release.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_burst(12'h123, 13'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 4096: RAM words; power of two.
REQ-002 SHALL have parameter WIDTH, default 16: data bits per word; a multiple of 8.
REQ-003 SHALL derive localparam ADDR_BITS = clog2(DEPTH).
REQ-004 SHALL have ports as follows; one clock, asynchronous active-high reset:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request a burst read; sampled only in IDLE.
- start_addr  in  ADDR_BITS  first word address.
- length  in  ADDR_BITS+1  words to read, 0..DEPTH.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse at burst end.
- address_b  out  ADDR_BITS  registered read address to RAM port B.
- rd_b  out  1  high in cycles where address_b carries a new issued read.
- q_b  in  WIDTH  RAM port B read data; valid one cycle after rd_b.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  WIDTH  stream data.
- out_last  out  1  marks final beat of burst.

Function
REQ-005 SHALL implement states IDLE, RUN, DRAIN.
REQ-006 IDLE->RUN on start=1 with length>0; latch start_addr into addr counter, length into remaining counter; busy=1 next cycle.
REQ-007 IDLE with start=1 and length=0 SHALL pulse done in the next cycle, issue no read, emit no beat, and stay IDLE.
REQ-008 start while busy SHALL be ignored.
REQ-009 In RUN a read SHALL issue (rd_b=1, address_b=addr) when fifo_count + inflight - pop < 2, where pop = out_valid & out_ready.
REQ-010 Each issue SHALL increment addr modulo DEPTH (DEPTH-1 wraps to 0) and decrement remaining.
REQ-011 RUN->DRAIN when the last read issues (remaining reaches 0).
REQ-012 q_b SHALL be captured into a 2-entry FIFO exactly one cycle after its rd_b cycle; the captured entry carries last=1 for the final issued read.
REQ-013 out_valid = FIFO non-empty; out_data/out_last = FIFO head; an entry pops on out_valid & out_ready.
REQ-014 out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 Latency: start sampled in cycle N -> rd_b/address_b=start_addr in N+1 -> first out_valid in N+3.
REQ-016 With out_ready held at 1, SHALL sustain one beat per cycle with no bubbles after the first.
REQ-017 The FIFO SHALL never overflow; a capture arriving while full is a design error (bench assertion).
REQ-018 DRAIN->IDLE when the out_last beat pops; done=1 and busy=0 in the following cycle.
REQ-019 done SHALL be exactly one cycle wide per accepted start.
REQ-020 Exactly length beats SHALL be emitted per burst, in address order.

Reset
REQ-021 reset=1 SHALL asynchronously force: state IDLE; busy=0; done=0; rd_b=0; address_b=0; out_valid=0; out_last=0; out_data=0; FIFO empty; inflight=0.
REQ-022 Reset mid-burst SHALL abort the burst; no beat or done follows release.
REQ-023 After reset deasserts, the first start SHALL be accepted on the following clock edge.

Structure
REQ-024 A shared package ram_stream_reader_pkg SHALL hold the state enum type (IDLE/RUN/DRAIN) and default DEPTH/WIDTH constants.
REQ-025 The 2-entry FIFO SHALL be a sub-module ram_stream_reader_fifo (WIDTH+1 bits: data plus last) with push, pop, count, head outputs.
REQ-026 The bench SHALL pair the block with ram_as_DxWb_rrw_p1p1 (DEPTH 4096, WIDTH 16), with port B on the same clock and the RAM preloaded via port A.

Verification
REQ-027 Preload mem[i]=i; start_addr=0x010, length=4, out_ready=1 -> beats 0x0010..0x0013; out_last on 4th; done once; first out_valid 3 cycles after start.
REQ-028 start_addr=0xFFE, length=4 -> beats from addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-029 length=8, out_ready toggling 1,0,0,1,... -> all 8 beats in order, data stable while stalled, no FIFO overflow assertion.
REQ-030 length=0 -> done one cycle after start; no rd_b, no out_valid.
REQ-031 start again while busy -> ignored; beat count equals the first length only.
REQ-032 reset asserted after 3 of 10 beats -> all outputs 0 immediately; a new burst with length=2 afterwards completes normally.
